// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Multi-cycle control sequencer for the RV32E NPC core. Each instruction
//   steps through fetch, execute, an optional memory access and a one-cycle
//   writeback. The sequencer owns the single shared memory port and qualifies
//   the decoder's write enables, so architectural state changes at most once
//   per instruction. An ebreak parks the core in HALT. A response error, a
//   watchdog timeout or an illegal load+store decode parks it in FAULT.
//
// Handshake rule (memory request channel): a request transfers on a cycle
// where mem_req_valid and mem_req_ready are both high. Once valid is raised,
// valid/fetch/we hold stable until that transfer happens. A response is
// mem_resp_valid high for one cycle. It is consumed only in FETCH_WAIT and
// MEM_WAIT and ignored in every other state.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   dec_reg_wen/mem_ren/mem_wen   decoder enables for the current instruction
//   dec_halt                      decoder flags ebreak
//   mem_req_valid/ready           memory request handshake
//   mem_req_fetch                 1 = instruction fetch, 0 = data access
//   mem_req_we                    data write request
//   mem_resp_valid/err            memory response and access fault
//   inst_load, ld_data_load       latch strobes for the IR and load-data register
//   pc_wen, rf_wen, retire        writeback strobes (WB only)
//   retired_cnt                   retired-instruction count
//   halted, fault, fault_code     sticky halt/fault status
//   dbg_state                     current FSM state, for observation
module exec_sequencer #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_reg_wen,
  input  logic             dec_mem_ren,
  input  logic             dec_mem_wen,
  input  logic             dec_halt,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_fetch,
  output logic             mem_req_we,
  input  logic             mem_resp_valid,
  input  logic             mem_resp_err,
  output logic             inst_load,
  output logic             ld_data_load,
  output logic             pc_wen,
  output logic             rf_wen,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    RST_IDLE   = 4'd0,
    FETCH_REQ  = 4'd1,
    FETCH_WAIT = 4'd2,
    EXEC       = 4'd3,
    MEM_REQ    = 4'd4,
    MEM_WAIT   = 4'd5,
    WB         = 4'd6,
    HALT       = 4'd7,
    FAULT      = 4'd8
  } state_e;

  localparam logic [1:0] CODE_RESP = 2'b01;
  localparam logic [1:0] CODE_WDOG = 2'b10;
  localparam logic [1:0] CODE_RW   = 2'b11;

  // The watchdog fires on the cycle whose count equals TIMEOUT-1. A stall of
  // TIMEOUT cycles therefore ends in FAULT on the following edge.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e           state_q;
  logic             we_q;      // store flag captured in EXEC, so mem_req_we is a state decode
  logic [TO_W-1:0]  wd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       code_q;
  logic             wd_expired;

  assign wd_expired = (TIMEOUT != 0) && (wd_q == TO_LAST);

  // Single registered FSM. wd_q clears by default on every cycle and only
  // counts up on the stall branches. That way any state change, handshake or
  // response restarts it, and a coinciding timeout loses to the progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_IDLE;
      we_q    <= 1'b0;
      wd_q    <= '0;
      cnt_q   <= '0;
      code_q  <= 2'b00;
    end else begin
      wd_q <= '0;
      case (state_q)
        RST_IDLE: state_q <= FETCH_REQ;

        FETCH_REQ: begin
          if (mem_req_ready) begin
            state_q <= FETCH_WAIT;
          end else if (wd_expired) begin
            state_q <= FAULT;
            code_q  <= CODE_WDOG;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        FETCH_WAIT: begin
          if (mem_resp_valid) begin
            if (mem_resp_err) begin
              state_q <= FAULT;
              code_q  <= CODE_RESP;
            end else begin
              state_q <= EXEC;
            end
          end else if (wd_expired) begin
            state_q <= FAULT;
            code_q  <= CODE_WDOG;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        EXEC: begin
          we_q <= dec_mem_wen;
          if (dec_halt) begin
            state_q <= HALT;
          end else if (dec_mem_ren && dec_mem_wen) begin
            state_q <= FAULT;
            code_q  <= CODE_RW;
          end else if (dec_mem_ren || dec_mem_wen) begin
            state_q <= MEM_REQ;
          end else begin
            state_q <= WB;
          end
        end

        MEM_REQ: begin
          if (mem_req_ready) begin
            state_q <= MEM_WAIT;
          end else if (wd_expired) begin
            state_q <= FAULT;
            code_q  <= CODE_WDOG;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        MEM_WAIT: begin
          if (mem_resp_valid) begin
            if (mem_resp_err) begin
              state_q <= FAULT;
              code_q  <= CODE_RESP;
            end else begin
              state_q <= WB;
            end
          end else if (wd_expired) begin
            state_q <= FAULT;
            code_q  <= CODE_WDOG;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        WB: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= FETCH_REQ;
        end

        HALT:    state_q <= HALT;
        FAULT:   state_q <= FAULT;
        default: state_q <= FAULT;
      endcase
    end
  end

  // Request signals are pure state decodes. No path exists from ready to valid.
  assign mem_req_valid = (state_q == FETCH_REQ) || (state_q == MEM_REQ);
  assign mem_req_fetch = (state_q == FETCH_REQ);
  assign mem_req_we    = (state_q == MEM_REQ) && we_q;

  // Latch strobes follow the response in the same cycle. An error blocks the latch.
  assign inst_load    = (state_q == FETCH_WAIT) && mem_resp_valid && !mem_resp_err;
  assign ld_data_load = (state_q == MEM_WAIT) && mem_resp_valid && !mem_resp_err && dec_mem_ren;

  assign pc_wen      = (state_q == WB);
  assign retire      = (state_q == WB);
  assign rf_wen      = (state_q == WB) && dec_reg_wen;
  assign retired_cnt = cnt_q;
  assign halted      = (state_q == HALT);
  assign fault       = (state_q == FAULT);
  assign fault_code  = code_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer. A small memory responder drives the request
// and response channel. Each test releases reset, so cycle 1 is the first
// FETCH_REQ. The expected retire/fault/halt events are pushed with
// hand-computed cycle stamps. A monitor pops them whenever the DUT shows one.
module tb_exec_sequencer;

  localparam int EW = 26;  // {kind[2], pc_wen, rf_wen, code[2], cnt[8], cyc[12]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_reg_wen = 1'b0, dec_mem_ren = 1'b0, dec_mem_wen = 1'b0, dec_halt = 1'b0;
  logic        mem_req_valid, mem_req_fetch, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
  logic        inst_load, ld_data_load, pc_wen, rf_wen, retire;
  logic [31:0] retired_cnt;
  logic        halted, fault;
  logic [1:0]  fault_code;
  logic [3:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  int cyc = 0;
  int stall_cfg = 0, dly_cfg = 1;
  bit err_cfg = 0, never_cfg = 0;
  int stall_left = 0, pend_dly = 0;
  bit pend = 0;
  int n_inst = 0, n_ld = 0, n_pc = 0, n_valid = 0;
  bit fault_seen = 0, halt_seen = 0;

  exec_sequencer #(.TIMEOUT(8), .TO_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .dec_reg_wen(dec_reg_wen), .dec_mem_ren(dec_mem_ren),
    .dec_mem_wen(dec_mem_wen), .dec_halt(dec_halt),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_fetch(mem_req_fetch), .mem_req_we(mem_req_we),
    .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
    .inst_load(inst_load), .ld_data_load(ld_data_load),
    .pc_wen(pc_wen), .rf_wen(rf_wen), .retire(retire),
    .retired_cnt(retired_cnt), .halted(halted), .fault(fault),
    .fault_code(fault_code), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle stamp ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [1:0] k, input logic pc, input logic rf,
                                       input logic [1:0] code, input logic [7:0] cnt,
                                       input logic [11:0] c);
    return {k, pc, rf, code, cnt, c};
  endfunction

  task automatic observe(input string name, input logic [EW-1:0] act);
    logic [EW-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: unexpected event %0h, none expected (cycle %0d)", name, act, cyc);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, e, cyc);
      end
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      if (pend) begin
        if (pend_dly <= 1) begin
          pend = 1'b0;
          if (!never_cfg) begin
            mem_resp_valid = 1'b1;
            mem_resp_err   = err_cfg;
          end
        end else begin
          pend_dly--;
        end
      end
      if (mem_req_valid && !rst) begin
        if (!mem_req_fetch && stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          pend = 1'b1;
          pend_dly = dly_cfg;
          if (!mem_req_fetch) stall_left = stall_cfg;
        end
      end else begin
        mem_req_ready = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (inst_load)     n_inst++;
        if (ld_data_load)  n_ld++;
        if (pc_wen)        n_pc++;
        if (mem_req_valid) n_valid++;
        if (retire)
          observe("retire_event", ev(2'd1, pc_wen, rf_wen, fault_code, retired_cnt[7:0], cyc[11:0]));
        if (fault && !fault_seen) begin
          fault_seen = 1'b1;
          observe("fault_event", ev(2'd2, pc_wen, rf_wen, fault_code, retired_cnt[7:0], cyc[11:0]));
        end
        if (halted && !halt_seen) begin
          halt_seen = 1'b1;
          observe("halt_event", ev(2'd3, pc_wen, rf_wen, fault_code, retired_cnt[7:0], cyc[11:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at negedge+1. Asserts reset mid-cycle, checks the async clear,
  // applies the new test setup and releases reset at a negedge.
  task automatic do_reset(input logic rw, input logic ren, input logic wen, input logic hlt,
                          input int stall, input int dly, input bit err, input bit never);
    #1;
    rst = 1'b1;
    pend = 1'b0;
    stall_cfg = stall; dly_cfg = dly; err_cfg = err; never_cfg = never;
    stall_left = stall;
    dec_reg_wen = rw; dec_mem_ren = ren; dec_mem_wen = wen; dec_halt = hlt;
    fault_seen = 1'b0; halt_seen = 1'b0;
    n_inst = 0; n_ld = 0; n_pc = 0; n_valid = 0;
    #1;
    chk("reset_outputs",
        {20'd0, mem_req_valid, mem_req_fetch, mem_req_we, inst_load, ld_data_load,
         pc_wen, rf_wen, retire, halted, fault, fault_code, retired_cnt}, 64'd0);
    chk("leftover_expected", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_state", dbg_state, 4'd0);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- safety bound ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "global timeout");
  end

  // ---------------- tests ----------------
  initial begin
    @(negedge clk);
    #1;

    // ADD then ADDI, zero-wait memory: WB at cycles 4 and 8.
    do_reset(1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd1, 1'b1, 1'b1, 2'b00, 8'd0, 12'd4));
    exp_q.push_back(ev(2'd1, 1'b1, 1'b1, 2'b00, 8'd1, 12'd8));
    run_to(9);
    chk("alu_retired_cnt", retired_cnt, 32'd2);
    chk("alu_pc_wen_count", n_pc, 2);
    chk("alu_inst_load_count", n_inst, 2);

    // LW with ready held low for 3 cycles in MEM_REQ. MEM_REQ spans 4..7, WB at 9.
    do_reset(1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd1, 1'b1, 1'b1, 2'b00, 8'd0, 12'd9));
    for (int c = 4; c <= 7; c++) begin
      run_to(c);
      chk("lw_req_stable", {mem_req_valid, mem_req_fetch, mem_req_we}, 3'b100);
    end
    run_to(10);
    chk("lw_ld_data_load_once", n_ld, 1);

    // SW: write request, no register write. WB at 6.
    do_reset(1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd1, 1'b1, 1'b0, 2'b00, 8'd0, 12'd6));
    run_to(4);
    chk("sw_req_we", {mem_req_valid, mem_req_fetch, mem_req_we}, 3'b101);
    run_to(7);
    chk("sw_no_ld_data_load", n_ld, 0);
    chk("sw_retired_cnt", retired_cnt, 32'd1);

    // Fetch response error: FAULT from cycle 3 with code 01, no further requests.
    do_reset(1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0);
    exp_q.push_back(ev(2'd2, 1'b0, 1'b0, 2'b01, 8'd0, 12'd3));
    run_to(10);
    chk("err_no_requests_after", n_valid, 1);
    chk("err_no_inst_load", n_inst, 0);
    chk("err_fault_code", fault_code, 2'b01);

    // Watchdog: FETCH_WAIT from cycle 2, no response, FAULT code 10 at cycle 10.
    do_reset(1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1);
    exp_q.push_back(ev(2'd2, 1'b0, 1'b0, 2'b10, 8'd0, 12'd10));
    run_to(9);
    chk("wdog_not_yet", fault, 1'b0);
    run_to(12);
    chk("wdog_fault_code", fault_code, 2'b10);

    // Response on the 8th FETCH_WAIT cycle (cycle 9) beats the timeout. EXEC 10, WB 11.
    do_reset(1'b1, 1'b0, 1'b0, 1'b0, 0, 8, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd1, 1'b1, 1'b1, 2'b00, 8'd0, 12'd11));
    run_to(10);
    chk("wdog_race_exec", dbg_state, 4'd3);
    run_to(11);
    chk("wdog_race_no_fault", {fault, fault_code}, 3'b000);

    // ebreak: HALT at cycle 4, nothing committed.
    do_reset(1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd3, 1'b0, 1'b0, 2'b00, 8'd0, 12'd4));
    run_to(10);
    chk("halt_no_pc_wen", n_pc, 0);
    chk("halt_retired_cnt", retired_cnt, 32'd0);
    chk("halt_no_requests_after", n_valid, 1);

    // Load and store both flagged: FAULT code 11 at cycle 4.
    do_reset(1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd2, 1'b0, 1'b0, 2'b11, 8'd0, 12'd4));
    run_to(6);
    chk("rw_fault_code", fault_code, 2'b11);

    // Reset in the middle of MEM_WAIT (cycle 5, load response present).
    do_reset(1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
    run_to(5);
    chk("mid_memwait_state", dbg_state, 4'd5);
    chk("mid_memwait_ld_load", ld_data_load, 1'b1);
    do_reset(1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
